// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the HD44780 bus decoder: instruction bit positions,
// FSM states and the address-counter wrap rule.
package lcd_bus_pkg;

  localparam int CMD_CLEAR     = 0;
  localparam int CMD_HOME      = 1;
  localparam int CMD_ENTRY     = 2;
  localparam int CMD_DISPLAY   = 3;
  localparam int CMD_SHIFT     = 4;
  localparam int CMD_FUNC      = 5;
  localparam int CMD_SET_CGRAM = 6;
  localparam int CMD_SET_DDRAM = 7;

  localparam logic [6:0] LINE2_BASE = 7'h40;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_EXEC} state_t;

  // Next AC value: in two-line mode the lines chain 0x00..last -> 0x40..0x40+last -> 0x00.
  function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc,
                                         input logic two_line, input logic [6:0] line_last);
    logic [6:0] line2_last;
    line2_last = LINE2_BASE + line_last;
    if (inc) begin
      if (ac == line_last)       return two_line ? LINE2_BASE : 7'h00;
      else if (ac == line2_last) return 7'h00;
      else                       return ac + 7'd1;
    end
    if (ac == 7'h00)             return two_line ? line2_last : line_last;
    else if (ac == LINE2_BASE)   return line_last;
    return ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// DDRAM mirror: simple dual-port array, synchronous write, registered read.
// Only the read register is reset; the array is filled by the clear sequence.
module lcd_ddram
  import lcd_bus_pkg::*;
#(
  parameter int DEPTH = 80,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  input  logic             rd_ok,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)  rd_data <= 8'h00;
    else       rd_data <= rd_ok ? mem[raddr] : 8'h00;
  end

endmodule

// File: rtl/lcd_bus_decoder.sv
// Snoops an HD44780-style LCD bus, decodes each write on the falling edge of E
// and keeps a mirror of DDRAM, the address counter and the mode flags.
module lcd_bus_decoder
  import lcd_bus_pkg::*;
#(
  parameter int         LINE_LEN     = 40,
  parameter logic [7:0] CLEAR_CHAR   = 8'h20,
  parameter int         CLEAR_CYCLES = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic [5:0] shift_ofs,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_dir,
  output logic       disp_shift,
  output logic       dl_8bit,
  output logic       two_line,
  output logic       cmd_valid,
  output logic       cmd_is_data,
  output logic [7:0] cmd_code,
  output logic       busy,
  output logic       err_rw,
  output logic       err_addr,
  output logic       err_overrun
);

  localparam int         DEPTH     = 2 * LINE_LEN;
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         CNT_W     = $clog2(CLEAR_CYCLES + 1);
  localparam logic [6:0] LINE_LAST = 7'(LINE_LEN - 1);
  localparam logic [5:0] OFS_LAST  = 6'(LINE_LEN - 1);

  function automatic logic addr_in_line(input logic [6:0] addr);
    return {1'b0, addr[5:0]} < 7'(LINE_LEN);
  endfunction

  function automatic logic [IDX_W-1:0] map_idx(input logic [6:0] addr);
    logic [IDX_W-1:0] base;
    base = addr[6] ? IDX_W'(LINE_LEN) : '0;
    return base + IDX_W'(addr[5:0]);
  endfunction

  function automatic logic [5:0] ofs_step(input logic [5:0] ofs, input logic inc);
    if (inc) return (ofs == OFS_LAST) ? 6'd0 : ofs + 6'd1;
    return (ofs == 6'd0) ? OFS_LAST : ofs - 6'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             e_q, rs_p0, rw_p0;
  logic [7:0]       data_p0;
  logic             strobe;

  logic [6:0]       ac_d;
  logic [5:0]       ofs_d;
  logic             disp_on_d, cursor_on_d, blink_on_d, inc_dir_d, disp_shift_d;
  logic             dl_8bit_d, two_line_d;
  logic             cmd_valid_d, cmd_is_data_d;
  logic [7:0]       cmd_code_d;
  logic             err_rw_d, err_addr_d, err_overrun_d;

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [7:0]       mem_wdata;

  assign strobe = e_q & ~LCD_E;
  assign busy   = (state_q == S_CLEAR);

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    ac_d          = cursor_addr;
    ofs_d         = shift_ofs;
    disp_on_d     = disp_on;
    cursor_on_d   = cursor_on;
    blink_on_d    = blink_on;
    inc_dir_d     = inc_dir;
    disp_shift_d  = disp_shift;
    dl_8bit_d     = dl_8bit;
    two_line_d    = two_line;
    cmd_valid_d   = 1'b0;
    cmd_is_data_d = cmd_is_data;
    cmd_code_d    = cmd_code;
    err_rw_d      = err_rw;
    err_addr_d    = err_addr;
    err_overrun_d = err_overrun;
    mem_we        = 1'b0;
    mem_waddr     = map_idx(cursor_addr);
    mem_wdata     = data_p0;

    case (state_q)
      S_CLEAR: begin
        mem_we    = int'(clr_cnt_q) < DEPTH;
        mem_waddr = IDX_W'(clr_cnt_q);
        mem_wdata = CLEAR_CHAR;
        clr_cnt_d = clr_cnt_q + CNT_W'(1);
        if (clr_cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end
        if (strobe) err_overrun_d = 1'b1;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (strobe) err_overrun_d = 1'b1;
      end
      default: begin
        if (strobe) begin
          state_d       = S_EXEC;
          cmd_valid_d   = 1'b1;
          cmd_is_data_d = rs_p0;
          cmd_code_d    = data_p0;
          if (rw_p0) begin
            err_rw_d = 1'b1;
          end else if (rs_p0) begin
            mem_we = addr_in_line(cursor_addr);
            ac_d   = ac_next(cursor_addr, inc_dir, two_line, LINE_LAST);
            if (disp_shift) ofs_d = ofs_step(shift_ofs, inc_dir);
          end else if (data_p0[CMD_SET_DDRAM]) begin
            // Line 2 addresses are only reachable once two-line mode is set.
            if (addr_in_line(data_p0[6:0]) && (!data_p0[6] || two_line)) ac_d = data_p0[6:0];
            else err_addr_d = 1'b1;
          end else if (data_p0[CMD_SET_CGRAM]) begin
            ac_d = cursor_addr;
          end else if (data_p0[CMD_FUNC]) begin
            dl_8bit_d  = data_p0[4];
            two_line_d = data_p0[3];
          end else if (data_p0[CMD_SHIFT]) begin
            if (data_p0[3]) ofs_d = ofs_step(shift_ofs, data_p0[2]);
            else            ac_d  = ac_next(cursor_addr, data_p0[2], two_line, LINE_LAST);
          end else if (data_p0[CMD_DISPLAY]) begin
            disp_on_d   = data_p0[2];
            cursor_on_d = data_p0[1];
            blink_on_d  = data_p0[0];
          end else if (data_p0[CMD_ENTRY]) begin
            inc_dir_d    = data_p0[1];
            disp_shift_d = data_p0[0];
          end else if (data_p0[CMD_HOME]) begin
            ac_d  = '0;
            ofs_d = '0;
          end else if (data_p0[CMD_CLEAR]) begin
            ac_d      = '0;
            ofs_d     = '0;
            inc_dir_d = 1'b1;
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
          end
        end
      end
    endcase
  end

  // Stage p0: bus capture (E edge detect, field latch) and decoded state update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      e_q         <= 1'b0;
      rs_p0       <= 1'b0;
      rw_p0       <= 1'b0;
      data_p0     <= 8'h00;
      cursor_addr <= '0;
      shift_ofs   <= '0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      inc_dir     <= 1'b1;
      disp_shift  <= 1'b0;
      dl_8bit     <= 1'b1;
      two_line    <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_is_data <= 1'b0;
      cmd_code    <= 8'h00;
      err_rw      <= 1'b0;
      err_addr    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      e_q         <= LCD_E;
      if (LCD_E) begin
        rs_p0   <= LCD_RS;
        rw_p0   <= LCD_RW;
        data_p0 <= LCD_DATA;
      end
      cursor_addr <= ac_d;
      shift_ofs   <= ofs_d;
      disp_on     <= disp_on_d;
      cursor_on   <= cursor_on_d;
      blink_on    <= blink_on_d;
      inc_dir     <= inc_dir_d;
      disp_shift  <= disp_shift_d;
      dl_8bit     <= dl_8bit_d;
      two_line    <= two_line_d;
      cmd_valid   <= cmd_valid_d;
      cmd_is_data <= cmd_is_data_d;
      cmd_code    <= cmd_code_d;
      err_rw      <= err_rw_d;
      err_addr    <= err_addr_d;
      err_overrun <= err_overrun_d;
    end
  end

  lcd_ddram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ddram (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr   (map_idx(rd_addr)),
    .rd_ok   (addr_in_line(rd_addr)),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: drives HD44780 bus writes, tracks expected commands
// in a queue and checks mirror state and DDRAM contents.
module tb_lcd_bus_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data, cmd_code;
  logic [6:0] cursor_addr;
  logic [5:0] shift_ofs;
  logic       disp_on, cursor_on, blink_on, inc_dir, disp_shift, dl_8bit, two_line;
  logic       cmd_valid, cmd_is_data, busy, err_rw, err_addr, err_overrun;

  int checks = 0;
  int errors = 0;
  logic [8:0] cmd_q [$];

  lcd_bus_decoder dut (
    .clk(clk), .rst(rst), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr), .shift_ofs(shift_ofs),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .inc_dir(inc_dir),
    .disp_shift(disp_shift), .dl_8bit(dl_8bit), .two_line(two_line), .cmd_valid(cmd_valid),
    .cmd_is_data(cmd_is_data), .cmd_code(cmd_code), .busy(busy), .err_rw(err_rw),
    .err_addr(err_addr), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted write must appear once, in order, on cmd_valid.
  always @(negedge clk) begin
    if (rst && cmd_valid) begin
      logic [8:0] exp;
      checks++;
      if (cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got rs=%0b code=%02h, required no command", cmd_is_data, cmd_code);
      end else begin
        exp = cmd_q.pop_front();
        if ({cmd_is_data, cmd_code} !== exp) begin
          errors++;
          $display("FAIL cmd_stream: got %03h, required %03h", {cmd_is_data, cmd_code}, exp);
        end
      end
    end
  end

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input bit accept);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    if (accept) cmd_q.push_back({rs, d});
    @(negedge clk);
    lcd_e = 1'b0;
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    strobe(rs, 1'b0, d, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic read_ddram(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b, required 1", busy); end
    checks++; if ({cursor_addr, shift_ofs} !== 13'h0) begin errors++; $display("FAIL rst_ac_ofs: got %02h/%02h, required 00/00", cursor_addr, shift_ofs); end
    checks++; if ({disp_on, cursor_on, blink_on, inc_dir, disp_shift, dl_8bit, two_line} !== 7'b0001010) begin
      errors++; $display("FAIL rst_flags: got %b, required 0001010", {disp_on, cursor_on, blink_on, inc_dir, disp_shift, dl_8bit, two_line}); end
    checks++; if ({cmd_valid, cmd_is_data, cmd_code, rd_data, err_rw, err_addr, err_overrun} !== 21'h0) begin
      errors++; $display("FAIL rst_outputs: got cmd %b/%b/%02h rd %02h err %b%b%b, required all 0", cmd_valid, cmd_is_data, cmd_code, rd_data, err_rw, err_addr, err_overrun); end
    @(negedge clk);
    rst = 1'b1;
    repeat (79) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy79: got %b, required 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy80: got %b, required 0", busy); end
    read_ddram(7'h00, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL init_rd00: got %02h, required 20", d); end
    read_ddram(7'h67, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL init_rd67: got %02h, required 20", d); end
    checks++; if ({inc_dir, dl_8bit, disp_on} !== 3'b110) begin errors++; $display("FAIL init_flags: got %b, required 110", {inc_dir, dl_8bit, disp_on}); end
  endtask

  task automatic test_config_data();
    logic [7:0] d;
    bus_write(1'b0, 8'h38);
    bus_write(1'b0, 8'h0F);
    bus_write(1'b0, 8'h06);
    bus_write(1'b1, 8'h39);
    checks++; if ({two_line, dl_8bit, disp_on, cursor_on, blink_on, inc_dir, disp_shift} !== 7'b1111110) begin
      errors++; $display("FAIL cfg_flags: got %b, required 1111110", {two_line, dl_8bit, disp_on, cursor_on, blink_on, inc_dir, disp_shift}); end
    checks++; if (cursor_addr !== 7'h01) begin errors++; $display("FAIL cfg_cursor: got %02h, required 01", cursor_addr); end
    read_ddram(7'h00, d);
    checks++; if (d !== 8'h39) begin errors++; $display("FAIL cfg_rd00: got %02h, required 39", d); end
  endtask

  task automatic test_wrap_shift();
    logic [7:0] d;
    bus_write(1'b0, 8'hA7);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("FAIL setdd_27: got %02h, required 27", cursor_addr); end
    bus_write(1'b1, 8'h34);
    checks++; if (cursor_addr !== 7'h40) begin errors++; $display("FAIL wrap_27_40: got %02h, required 40", cursor_addr); end
    read_ddram(7'h27, d);
    checks++; if (d !== 8'h34) begin errors++; $display("FAIL wrap_rd27: got %02h, required 34", d); end
    bus_write(1'b0, 8'h10);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("FAIL shift_left: got %02h, required 27", cursor_addr); end
    bus_write(1'b0, 8'h14);
    checks++; if (cursor_addr !== 7'h40) begin errors++; $display("FAIL shift_right: got %02h, required 40", cursor_addr); end
  endtask

  task automatic test_errors();
    logic [7:0] d;
    bus_write(1'b0, 8'hB0);
    checks++; if ({err_addr, cursor_addr} !== {1'b1, 7'h40}) begin errors++; $display("FAIL err_addr: got %b/%02h, required 1/40", err_addr, cursor_addr); end
    strobe(1'b1, 1'b1, 8'h55, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if ({err_rw, err_overrun, cursor_addr} !== {2'b10, 7'h40}) begin errors++; $display("FAIL err_rw: got %b%b/%02h, required 10/40", err_rw, err_overrun, cursor_addr); end
    read_ddram(7'h40, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL err_rw_mem: got %02h, required 20", d); end
  endtask

  task automatic test_display_shift();
    logic [7:0] d;
    bus_write(1'b0, 8'h07);
    bus_write(1'b1, 8'h41);
    checks++; if ({cursor_addr, shift_ofs} !== {7'h41, 6'd1}) begin errors++; $display("FAIL dshift_data: got %02h/%0d, required 41/1", cursor_addr, shift_ofs); end
    bus_write(1'b0, 8'h18);
    bus_write(1'b0, 8'h18);
    checks++; if (shift_ofs !== 6'd39) begin errors++; $display("FAIL dshift_wrap: got %0d, required 39", shift_ofs); end
    bus_write(1'b0, 8'h04);
    bus_write(1'b1, 8'h42);
    bus_write(1'b1, 8'h43);
    checks++; if ({inc_dir, cursor_addr, shift_ofs} !== {1'b0, 7'h27, 6'd39}) begin errors++; $display("FAIL dec_wrap: got %b/%02h/%0d, required 0/27/39", inc_dir, cursor_addr, shift_ofs); end
    read_ddram(7'h41, d);
    checks++; if (d !== 8'h42) begin errors++; $display("FAIL dec_rd41: got %02h, required 42", d); end
    read_ddram(7'h40, d);
    checks++; if (d !== 8'h43) begin errors++; $display("FAIL dec_rd40: got %02h, required 43", d); end
    bus_write(1'b0, 8'h02);
    checks++; if ({cursor_addr, shift_ofs} !== 13'h0) begin errors++; $display("FAIL home: got %02h/%0d, required 00/0", cursor_addr, shift_ofs); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    bus_write(1'b0, 8'h06);
    strobe(1'b1, 1'b0, 8'h61, 1'b1);
    strobe(1'b1, 1'b0, 8'h62, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if ({err_overrun, cursor_addr} !== {1'b0, 7'h02}) begin errors++; $display("FAIL b2b_state: got %b/%02h, required 0/02", err_overrun, cursor_addr); end
    read_ddram(7'h00, d);
    checks++; if (d !== 8'h61) begin errors++; $display("FAIL b2b_rd00: got %02h, required 61", d); end
    read_ddram(7'h01, d);
    checks++; if (d !== 8'h62) begin errors++; $display("FAIL b2b_rd01: got %02h, required 62", d); end
  endtask

  task automatic test_clear_overrun();
    logic [7:0] d;
    logic [6:0] av;
    int bad;
    bus_write(1'b0, 8'h04);
    bus_write(1'b0, 8'h01);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b, required 1", busy); end
    repeat (6) @(negedge clk);
    strobe(1'b1, 1'b0, 8'h58, 1'b0);
    @(negedge clk);
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun: got %b, required 1", err_overrun); end
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_timeout: busy got %b, required 0", busy); end
    checks++; if ({cursor_addr, shift_ofs, inc_dir} !== {13'h0, 1'b1}) begin errors++; $display("FAIL clr_state: got %02h/%0d/%b, required 00/0/1", cursor_addr, shift_ofs, inc_dir); end
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      av = 7'(a);
      if (av[5:0] < 6'd40) begin
        read_ddram(av, d);
        checks++;
        if (d !== 8'h20) begin errors++; bad++; if (bad < 4) $display("FAIL clr_fill[%02h]: got %02h, required 20", av, d); end
      end
    end
    read_ddram(7'h30, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rd_illegal: got %02h, required 00", d); end
  endtask

  task automatic test_reset_mid_clear();
    bus_write(1'b0, 8'h01);
    repeat (37) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if ({two_line, disp_on, cursor_on, blink_on, inc_dir, dl_8bit, err_rw, err_addr, err_overrun} !== 9'b000011000) begin
      errors++; $display("FAIL mid_rst_flags: got %b, required 000011000", {two_line, disp_on, cursor_on, blink_on, inc_dir, dl_8bit, err_rw, err_addr, err_overrun}); end
    checks++; if ({cmd_code, rd_data, busy} !== {16'h0, 1'b1}) begin errors++; $display("FAIL mid_rst_out: got %02h/%02h/%b, required 00/00/1", cmd_code, rd_data, busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (79) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy79: got %b, required 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy80: got %b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_config_data();
    test_wrap_shift();
    test_errors();
    test_display_shift();
    test_back_to_back();
    test_clear_overrun();
    test_reset_mid_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_q.size() != 0) begin errors++; $display("FAIL cmd_missing: got %0d pending, required 0", cmd_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
